// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and constants for the AXI read arbiter slice.
//   arb_state_e      - arbiter FSM states (IDLE, ADDR, RESP)
//   REQ_IF / REQ_LS  - requester ids (instruction fetch, load/store)
//   ADDR_W_DEF / DATA_W_DEF - default address / data widths
package axi_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational two-way request picker.
//   req[1:0]    in  - request vector, bit REQ_IF = fetch, bit REQ_LS = load/store
//   last_grant  in  - id of the most recently completed owner
//   gnt_valid   out - some request is present
//   gnt_id      out - id of the winner
// Tie policy: macro ARB_ROUND_ROBIN_EN selects alternation (winner is the
// requester that did not win last); otherwise load/store wins every tie.
module arb_pick2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

`ifndef ARB_ROUND_ROBIN_EN
  // last_grant is tracked by the parent regardless of policy; fixed priority ignores it.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_IF;
    if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt_id = ~last_grant;
`else
      gnt_id = REQ_LS;
`endif
    end else if (req[REQ_LS]) begin
      gnt_id = REQ_LS;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read channel between instruction fetch
// (io_if_*) and load/store (io_ls_*), one outstanding transaction at a time.
//   clock, reset              - single clock, synchronous active-high reset
//   io_if_* / io_ls_*         - requester AR (araddr/arvalid/arready) and
//                               R (rvalid/rready/rdata) handshakes
//   io_mem_*                  - AXI read address / read data towards memory
// The winner's address is latched at grant; the response goes to the owner only.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-breaking (default: LSU wins ties).
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] io_if_araddr,
  input  logic              io_if_arvalid,
  output logic              io_if_arready,
  output logic              io_if_rvalid,
  input  logic              io_if_rready,
  output logic [DATA_W-1:0] io_if_rdata,
  input  logic [ADDR_W-1:0] io_ls_araddr,
  input  logic              io_ls_arvalid,
  output logic              io_ls_arready,
  output logic              io_ls_rvalid,
  input  logic              io_ls_rready,
  output logic [DATA_W-1:0] io_ls_rdata,
  output logic [ADDR_W-1:0] io_mem_araddr,
  output logic              io_mem_arvalid,
  input  logic              io_mem_arready,
  input  logic              io_mem_rvalid,
  output logic              io_mem_rready,
  input  logic [DATA_W-1:0] io_mem_rdata
);

  arb_state_e        state, state_nxt;
  logic              owner;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic              gnt_valid;
  logic              gnt_id;
  logic              owner_rready;
  logic              grant;
  logic              resp_done;

  arb_pick2 u_pick (
    .req        ({io_ls_arvalid, io_if_arvalid}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign owner_rready = (owner == REQ_LS) ? io_ls_rready : io_if_rready;
  assign grant        = (state == IDLE) && gnt_valid;
  assign resp_done    = (state == RESP) && io_mem_rvalid && owner_rready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= REQ_IF;
      addr_q     <= '0;
      last_grant <= REQ_LS;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner  <= gnt_id;
        addr_q <= (gnt_id == REQ_LS) ? io_ls_araddr : io_if_araddr;
      end
      if (resp_done) begin
        last_grant <= owner;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    io_if_arready  = 1'b0;
    io_ls_arready  = 1'b0;
    io_if_rvalid   = 1'b0;
    io_ls_rvalid   = 1'b0;
    io_if_rdata    = '0;
    io_ls_rdata    = '0;
    io_mem_arvalid = 1'b0;
    io_mem_araddr  = addr_q;
    io_mem_rready  = 1'b0;

    case (state)
      IDLE: begin
        if (gnt_valid) begin
          io_if_arready = (gnt_id == REQ_IF);
          io_ls_arready = (gnt_id == REQ_LS);
          state_nxt     = ADDR;
        end
      end
      ADDR: begin
        io_mem_arvalid = 1'b1;
        if (io_mem_arready) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        io_mem_rready = owner_rready;
        if (owner == REQ_LS) begin
          io_ls_rvalid = io_mem_rvalid;
          io_ls_rdata  = io_mem_rdata;
        end else begin
          io_if_rvalid = io_mem_rvalid;
          io_if_rdata  = io_mem_rdata;
        end
        if (resp_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed-vector bench for axi_read_arbiter.
// Expected tie order follows macro ARB_ROUND_ROBIN_EN when defined.
module tb_axi_read_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_araddr, ls_araddr, mem_araddr;
  logic        if_arvalid, if_arready, if_rvalid, if_rready;
  logic        ls_arvalid, ls_arready, ls_rvalid, ls_rready;
  logic [63:0] if_rdata, ls_rdata, mem_rdata;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;

  int unsigned vec_count = 0;
  int unsigned err_count = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  axi_read_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_if_araddr   (if_araddr),
    .io_if_arvalid  (if_arvalid),
    .io_if_arready  (if_arready),
    .io_if_rvalid   (if_rvalid),
    .io_if_rready   (if_rready),
    .io_if_rdata    (if_rdata),
    .io_ls_araddr   (ls_araddr),
    .io_ls_arvalid  (ls_arvalid),
    .io_ls_arready  (ls_arready),
    .io_ls_rvalid   (ls_rvalid),
    .io_ls_rready   (ls_rready),
    .io_ls_rdata    (ls_rdata),
    .io_mem_araddr  (mem_araddr),
    .io_mem_arvalid (mem_arvalid),
    .io_mem_arready (mem_arready),
    .io_mem_rvalid  (mem_rvalid),
    .io_mem_rready  (mem_rready),
    .io_mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow a further #1.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    if_araddr   = '0;
    ls_araddr   = '0;
    if_arvalid  = 1'b0;
    ls_arvalid  = 1'b0;
    if_rready   = 1'b0;
    ls_rready   = 1'b0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset_dut();
    #1;
    check_vec("rst_mem_arvalid", mem_arvalid, 0);
    check_vec("rst_mem_araddr", mem_araddr, 0);
    check_vec("rst_mem_rready", mem_rready, 0);
    check_vec("rst_if_rvalid", if_rvalid, 0);
    check_vec("rst_ls_rvalid", ls_rvalid, 0);
    check_vec("rst_if_arready", if_arready, 0);
    check_vec("rst_ls_arready", ls_arready, 0);

    // Single IFU request: grant in cycle 0, mem_arvalid held two cycles.
    tick();
    if_araddr  = 32'h8000_0000;
    if_arvalid = 1'b1;
    #1;
    check_vec("single_if_arready", if_arready, 1);
    check_vec("single_ls_arready", ls_arready, 0);
    check_vec("single_mem_arvalid_c0", mem_arvalid, 0);
    tick();
    if_arvalid = 1'b0;
    if_araddr  = 32'h1234_5678;
    #1;
    check_vec("single_mem_arvalid_c1", mem_arvalid, 1);
    check_vec("single_mem_araddr_c1", mem_araddr, 64'h8000_0000);
    check_vec("single_if_arready_busy", if_arready, 0);
    tick();
    mem_arready = 1'b1;
    #1;
    check_vec("single_mem_arvalid_c2", mem_arvalid, 1);
    check_vec("single_mem_araddr_c2", mem_araddr, 64'h8000_0000);
    tick();
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 64'h0000_0013_0000_0093;
    if_rready   = 1'b1;
    #1;
    check_vec("single_mem_arvalid_resp", mem_arvalid, 0);
    check_vec("single_if_rvalid", if_rvalid, 1);
    check_vec("single_if_rdata", if_rdata, 64'h0000_0013_0000_0093);
    check_vec("single_ls_rvalid", ls_rvalid, 0);
    check_vec("single_ls_rdata", ls_rdata, 0);
    check_vec("single_mem_rready", mem_rready, 1);
    tick();
    clear_inputs();
    #1;
    check_vec("single_done_if_rvalid", if_rvalid, 0);
    check_vec("single_done_mem_rready", mem_rready, 0);

    // Tie: both requesters valid for four transactions.
    reset_dut();
    if_arvalid = 1'b1;
    ls_arvalid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic exp_ls;
      exp_ls    = RR ? (t % 2 == 1) : 1'b1;
      if_araddr = 32'h0000_1000 + 32'(t);
      ls_araddr = 32'h0000_2000 + 32'(t);
      #1;
      check_vec($sformatf("tie%0d_if_arready", t), if_arready, !exp_ls);
      check_vec($sformatf("tie%0d_ls_arready", t), ls_arready, exp_ls);
      tick();
      mem_arready = 1'b1;
      #1;
      check_vec($sformatf("tie%0d_mem_araddr", t), mem_araddr,
                exp_ls ? 64'h2000 + 64'(t) : 64'h1000 + 64'(t));
      tick();
      mem_arready = 1'b0;
      mem_rvalid  = 1'b1;
      mem_rdata   = 64'hA5A5_0000_0000_0100 + 64'(t);
      if_rready   = 1'b1;
      ls_rready   = 1'b1;
      #1;
      check_vec($sformatf("tie%0d_if_rvalid", t), if_rvalid, !exp_ls);
      check_vec($sformatf("tie%0d_ls_rvalid", t), ls_rvalid, exp_ls);
      check_vec($sformatf("tie%0d_rdata", t), exp_ls ? ls_rdata : if_rdata,
                64'hA5A5_0000_0000_0100 + 64'(t));
      tick();
      mem_rvalid = 1'b0;
      if_rready  = 1'b0;
      ls_rready  = 1'b0;
    end
    clear_inputs();

    // Response backpressure: owner rready low three cycles.
    reset_dut();
    if_araddr  = 32'h0000_4000;
    if_arvalid = 1'b1;
    tick();
    if_arvalid  = 1'b0;
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 64'hDEAD_BEEF_0000_0001;
    if_rready   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if_arvalid = 1'b1;
      #1;
      check_vec($sformatf("bp%0d_mem_rready", c), mem_rready, 0);
      check_vec($sformatf("bp%0d_if_arready", c), if_arready, 0);
      tick();
    end
    if_arvalid = 1'b0;
    if_rready  = 1'b1;
    #1;
    check_vec("bp_mem_rready", mem_rready, 1);
    check_vec("bp_if_rdata", if_rdata, 64'hDEAD_BEEF_0000_0001);
    tick();
    clear_inputs();
    #1;
    check_vec("bp_done_if_rvalid", if_rvalid, 0);

    // LSU request while IFU is busy.
    reset_dut();
    if_araddr  = 32'h0000_5000;
    if_arvalid = 1'b1;
    #1;
    check_vec("busy_if_arready", if_arready, 1);
    tick();
    if_arvalid = 1'b0;
    ls_araddr  = 32'h0000_6000;
    ls_arvalid = 1'b1;
    #1;
    check_vec("busy_addr_ls_arready", ls_arready, 0);
    check_vec("busy_addr_mem_araddr", mem_araddr, 64'h5000);
    tick();
    mem_arready = 1'b1;
    #1;
    check_vec("busy_addr2_ls_arready", ls_arready, 0);
    tick();
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 64'h1111;
    if_rready   = 1'b1;
    #1;
    check_vec("busy_resp_ls_arready", ls_arready, 0);
    check_vec("busy_resp_ls_rvalid", ls_rvalid, 0);
    tick();
    mem_rvalid = 1'b0;
    if_rready  = 1'b0;
    #1;
    check_vec("busy_idle_ls_arready", ls_arready, 1);
    check_vec("busy_idle_mem_arvalid", mem_arvalid, 0);
    tick();
    ls_arvalid = 1'b0;
    #1;
    check_vec("busy_ls_mem_araddr", mem_araddr, 64'h6000);
    clear_inputs();

    // Reset while in RESP; a late memory response must be ignored.
    reset_dut();
    if_araddr  = 32'h0000_7000;
    if_arvalid = 1'b1;
    tick();
    if_arvalid  = 1'b0;
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    #1;
    check_vec("rstresp_pre_mem_arvalid", mem_arvalid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_vec("rstresp_mem_arvalid", mem_arvalid, 0);
    check_vec("rstresp_mem_araddr", mem_araddr, 0);
    check_vec("rstresp_mem_rready", mem_rready, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    if_rready  = 1'b1;
    #1;
    check_vec("rstresp_late_if_rvalid", if_rvalid, 0);
    check_vec("rstresp_late_if_rdata", if_rdata, 0);
    check_vec("rstresp_late_mem_rready", mem_rready, 0);
    ls_arvalid = 1'b1;
    ls_araddr  = 32'h0000_8000;
    #1;
    check_vec("rstresp_idle_ls_arready", ls_arready, 1);
    tick();
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
